// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 4-channel round-robin arbiter/mux.
// Latency: none (types and a pure helper only).
// Backpressure: not applicable.
package rr_arb_pkg;

    localparam int N_CH = 4;

    // Channel index; wraps naturally modulo N_CH.
    typedef logic [1:0] ch_idx_t;

    // Occupancy of the single output register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // One-hot select vector for a channel index.
    function automatic logic [N_CH-1:0] idx_onehot(input ch_idx_t idx);
        logic [N_CH-1:0] one;
        one = {{(N_CH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Generic W-bit 4:1 data multiplexer.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module mux_4_1 #(
    parameter int W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    // Route the selected input to the output.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter over 4 valid/ready channels feeding one registered output word.
// Latency: 1 cycle from accepted input to out_valid/y/sel; one word per cycle sustained.
// Backpressure: in_ready is all-zero while the output register is full and out_ready is low.
module rr_arb_mux_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    output logic [3:0]      in_ready,
    input  logic [W-1:0]    d0,
    input  logic [W-1:0]    d1,
    input  logic [W-1:0]    d2,
    input  logic [W-1:0]    d3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic [1:0]      sel
);

    state_t         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    ch_idx_t        sel_q, sel_d;
    ch_idx_t        last_q, last_d;

    ch_idx_t        win_idx;
    ch_idx_t        cand;
    logic           win_found;
    logic           can_accept;
    logic           accept;
    logic [W-1:0]   mux_y;

    // Winner search: start one past the last grant and walk upward with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q + 2'd1;
        cand      = last_q;
        for (int k = 1; k <= N_CH; k++) begin
            cand = last_q + ch_idx_t'(k);
            if (!win_found && in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The register can take a new word if it is empty or being drained this cycle.
    assign can_accept = (state_q == ST_EMPTY) || out_ready;
    assign accept     = !rst && can_accept && win_found;
    assign in_ready   = accept ? idx_onehot(win_idx) : 4'b0000;

    // Data selection is driven only by the combinational winner index.
    mux_4_1 #(
        .W (W)
    ) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (win_idx),
        .y   (mux_y)
    );

    // Next-state: load on accept, drop to empty when drained with nothing to reload.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    y_d     = mux_y;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    y_d    = mux_y;
                    sel_d  = win_idx;
                    last_d = win_idx;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State registers; reset parks the pointer on the top channel so channel 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            sel_q   <= '0;
            last_q  <= ch_idx_t'(N_CH - 1);
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign y         = y_q;
    assign sel       = sel_q;

endmodule
